// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Hazard / flush / halt / debug-step controller for a 5-stage
//               pipeline. Optional load-use stall counter behind the macro
//               PIPELINE_CTRL_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        branch_taken,
    input  logic        halt_instr,
    input  logic        dbg_step,
    input  logic        dbg_run,
    output logic        pc_write,
    output logic        if_id_enable,
    output logic        if_id_clear,
    output logic        id_ex_clear,
    output logic        halted
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_HALT  = 2'd2,
        S_STEP  = 2'd3
    } state_t;

    localparam logic [1:0] c_DRAIN_LOAD = 2'd2;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_drain_cnt;
    logic [1:0] w_drain_cnt_nxt;
    logic       w_hazard;
    logic       w_halt_go;

    // Register 0 is hardwired, so a load to it never creates a dependency.
    assign w_hazard  = ex_mem_read && (ex_rt != 5'd0) &&
                       ((ex_rt == id_rs) || (ex_rt == id_rt));
    assign w_halt_go = !w_hazard && !branch_taken && halt_instr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_RUN;
            r_drain_cnt <= 2'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        pc_write        = 1'b0;
        if_id_enable    = 1'b0;
        if_id_clear     = 1'b0;
        id_ex_clear     = 1'b0;
        halted          = 1'b0;

        case (r_state)
            S_RUN, S_STEP: begin
                if (w_hazard) begin
                    id_ex_clear = 1'b1;
                end else if (branch_taken) begin
                    pc_write     = 1'b1;
                    if_id_enable = 1'b1;
                    if_id_clear  = 1'b1;
                end else if (halt_instr) begin
                    if_id_enable = 1'b1;
                    if_id_clear  = 1'b1;
                end else begin
                    pc_write     = 1'b1;
                    if_id_enable = 1'b1;
                end

                if (w_halt_go) begin
                    w_state_nxt     = S_DRAIN;
                    w_drain_cnt_nxt = c_DRAIN_LOAD;
                end else if (r_state == S_STEP) begin
                    w_state_nxt = S_HALT;
                end
            end
            S_DRAIN: begin
                if_id_enable = 1'b1;
                if_id_clear  = 1'b1;
                id_ex_clear  = 1'b1;
                // Counter runs 2,1,0 so the drain spans three cycles.
                if (r_drain_cnt == 2'd0) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_drain_cnt_nxt = r_drain_cnt - 2'd1;
                end
            end
            S_HALT: begin
                halted = 1'b1;
                if (dbg_run) begin
                    w_state_nxt = S_RUN;
                end else if (dbg_step) begin
                    w_state_nxt = S_STEP;
                end
            end
            default: begin
                w_state_nxt = S_RUN;
            end
        endcase

        // Reset forces a flushed, frozen front end regardless of state.
        if (!reset) begin
            pc_write     = 1'b0;
            if_id_enable = 1'b0;
            if_id_clear  = 1'b1;
            id_ex_clear  = 1'b1;
            halted       = 1'b0;
        end
    end

`ifdef PIPELINE_CTRL_STALL_CNT_EN
    logic        w_stall;
    logic [15:0] r_stall_cnt;

    assign w_stall = w_hazard && ((r_state == S_RUN) || (r_state == S_STEP));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= 16'd0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_count = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Scoreboard bench for pipeline_ctrl; expected outputs come from
//               a behavioural model pushed per cycle and popped at sampling.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        ex_mem_read;
    logic [4:0]  ex_rt;
    logic        branch_taken;
    logic        halt_instr;
    logic        dbg_step;
    logic        dbg_run;
    logic        pc_write;
    logic        if_id_enable;
    logic        if_id_clear;
    logic        id_ex_clear;
    logic        halted;
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    pipeline_ctrl u_dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .halt_instr   (halt_instr),
        .dbg_step     (dbg_step),
        .dbg_run      (dbg_run),
        .pc_write     (pc_write),
        .if_id_enable (if_id_enable),
        .if_id_clear  (if_id_clear),
        .id_ex_clear  (id_ex_clear),
        .halted       (halted)
`ifdef PIPELINE_CTRL_STALL_CNT_EN
        ,
        .stall_count  (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model states
    localparam int c_M_RUN   = 0;
    localparam int c_M_DRAIN = 1;
    localparam int c_M_HALT  = 2;
    localparam int c_M_STEP  = 3;

    int m_state;
    int m_drain_left;
    int m_stalls;
    int n_checks;
    int n_errors;

    // Entry: {pc_write, if_id_enable, if_id_clear, id_ex_clear, halted, stall_count}
    logic [20:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] dut_outs();
        return {pc_write, if_id_enable, if_id_clear, id_ex_clear, halted};
    endfunction

    // Drive one cycle of inputs (called at the falling edge), predict, sample, advance.
    task automatic cycle(input string tag,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic mr, input logic [4:0] ert,
                         input logic br, input logic hi,
                         input logic stp, input logic run);
        logic        haz;
        logic [4:0]  exp;
        int          nxt;
        int          nleft;
        int          nstalls;
        logic [20:0] ent;
        id_rs = rs; id_rt = rt; ex_mem_read = mr; ex_rt = ert;
        branch_taken = br; halt_instr = hi; dbg_step = stp; dbg_run = run;

        haz     = mr && (ert != 5'd0) && (ert == rs || ert == rt);
        nxt     = m_state;
        nleft   = m_drain_left;
        nstalls = m_stalls;
        exp     = 5'b00000;
        if (m_state == c_M_RUN || m_state == c_M_STEP) begin
            nxt = (m_state == c_M_STEP) ? c_M_HALT : c_M_RUN;
            if (haz) begin
                exp = 5'b00010;
                if (nstalls < 65535) nstalls++;
            end else if (br) begin
                exp = 5'b11100;
            end else if (hi) begin
                exp   = 5'b01100;
                nxt   = c_M_DRAIN;
                nleft = 3;
            end else begin
                exp = 5'b11000;
            end
        end else if (m_state == c_M_DRAIN) begin
            exp   = 5'b01110;
            nleft = m_drain_left - 1;
            if (nleft == 0) nxt = c_M_HALT;
        end else begin
            exp = 5'b00001;
            if (run) nxt = c_M_RUN;
            else if (stp) nxt = c_M_STEP;
        end
        sb_q.push_back({exp, m_stalls[15:0]});

        #2;
        ent = sb_q.pop_front();
        chk(tag, {27'd0, dut_outs()}, {27'd0, ent[20:16]});
`ifdef PIPELINE_CTRL_STALL_CNT_EN
        chk({tag, "_cnt"}, {16'd0, stall_count}, {16'd0, ent[15:0]});
`endif
        @(posedge clk);
        m_state      = nxt;
        m_drain_left = nleft;
        m_stalls     = nstalls;
        @(negedge clk);
    endtask

    task automatic idle(input string tag, input logic stp, input logic run);
        cycle(tag, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, stp, run);
    endtask

    initial begin
        n_checks = 0; n_errors = 0;
        m_state = c_M_RUN; m_drain_left = 0; m_stalls = 0;
        reset = 1'b0;
        id_rs = '0; id_rt = '0; ex_mem_read = 1'b0; ex_rt = '0;
        branch_taken = 1'b0; halt_instr = 1'b0; dbg_step = 1'b0; dbg_run = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", {27'd0, dut_outs()}, 32'h06);
`ifdef PIPELINE_CTRL_STALL_CNT_EN
        chk("rst_cnt", {16'd0, stall_count}, 32'd0);
`endif
        reset = 1'b1;

        idle("run_first", 1'b0, 1'b0);
        cycle("loaduse",   5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        idle("after_lu", 1'b0, 1'b0);
        cycle("zeroreg",   5'd4, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("lu_rt",     5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("nolu_norm", 5'd1, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle("br_haz",    5'd3, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("br_only",   5'd3, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle("br_halt",   5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle("haz_halt",  5'd6, 5'd2, 1'b1, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0);
        idle("run_dbg_ign", 1'b1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            cycle("rand_run", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'b0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        cycle("halt", 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("drain", 5'd5, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            cycle("halt_hold", 5'd5, 5'd5, 1'b1, 5'd5, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        idle("dbg_step", 1'b1, 1'b0);
        idle("step_run", 1'b1, 1'b0);
        idle("step_back", 1'b0, 1'b0);

        idle("dbg_step2", 1'b1, 1'b0);
        cycle("step_haz", 5'd8, 5'd2, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0);
        idle("step_haz_back", 1'b0, 1'b0);

        idle("dbg_step3", 1'b1, 1'b0);
        cycle("step_halt", 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) idle("step_drain", 1'b0, 1'b1);

        idle("dbg_both", 1'b1, 1'b1);
        idle("resumed", 1'b0, 1'b0);
        cycle("lu_again", 5'd2, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);

        cycle("halt2", 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle("drain2", 1'b0, 1'b0);

        // Asynchronous reset in the middle of the drain.
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_outs", {27'd0, dut_outs()}, 32'h06);
`ifdef PIPELINE_CTRL_STALL_CNT_EN
        chk("async_rst_cnt", {16'd0, stall_count}, 32'd0);
`endif
        m_state = c_M_RUN; m_drain_left = 0; m_stalls = 0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) idle("post_rst", 1'b0, 1'b0);
        cycle("post_rst_lu", 5'd3, 5'd4, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        idle("post_rst_end", 1'b0, 1'b0);

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
